// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel synchronizer, stability counter,
// debounced level and one-cycle press/release pulses.
//
// Effective per-channel states (derived from cnt and s vs. level):
//   state   | meaning
//   STABLE  | synchronized input equals debounced level, cnt = 0
//   PENDING | synchronized input differs, cnt counting toward commit
// A return to the debounced value while PENDING discards the count.
module button_debouncer #(
    parameter int NUM_BTN       = 5,
    parameter int STABLE_CYCLES = 250_000,
    parameter int CNT_WIDTH     = 18,
    parameter int SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q;
    logic [NUM_BTN-1:0]                  s;
    logic [NUM_BTN-1:0][CNT_WIDTH-1:0]   cnt;
    logic [NUM_BTN-1:0][CNT_WIDTH-1:0]   cnt_nxt;
    logic [NUM_BTN-1:0]                  level_nxt;
    logic [NUM_BTN-1:0]                  press_nxt;
    logic [NUM_BTN-1:0]                  release_nxt;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain shift chain, no logic between stages, stage 0 takes the raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Per-channel stability decision: clear on agreement, count on
    // disagreement, commit and pulse once the count reaches its terminal value.
    always_comb begin
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (s[i] == btn_level[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_TERM) begin
                cnt_nxt[i]     = '0;
                level_nxt[i]   = s[i];
                press_nxt[i]   = s[i];
                release_nxt[i] = ~s[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Counter, debounced level and pulse registers; pulses last one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

endmodule
